lamp_timer_ctrl: RTL and testbench

- Parametrised timed lamp controller for the lab board: `N_SW` switches each toggle one lamp (multi-way switching).
- The lamp turns off automatically after a programmable on-time.
- An optional blinking warning phase precedes switch-off.
- Selectable mode: a press while lit either switches the lamp off or restarts its timer.
- Sits between the board switch inputs and the LED drive; successor of the fixed 3-switch timed lamp block.

---
 rtl/lamp_timer_pkg.sv | 14 +
 rtl/sw_event_sync.sv | 36 +++
 rtl/lamp_timer_ctrl.sv | 133 +++++++++++++
 tb/tb_lamp_timer_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lamp_timer_pkg.sv
// Shared encodings for the timed lamp controller.
// The lamp state register and the press-mode selector both use these values.
package lamp_timer_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_WARN = 2'd2
    } lamp_state_t;

    localparam int MODE_TOGGLE = 0;
    localparam int MODE_RETRIG = 1;

endpackage

// File: rtl/sw_event_sync.sv
// Multi-way switch front end: synchronises the raw switch levels and
// turns any change in their overall parity into a single-cycle event.
module sw_event_sync #(
    parameter int N_SW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw,
    output logic            evt
);

    logic [N_SW-1:0] sync1, sync2;
    logic            par, par_q;
    logic [2:0]      vld_pipe;

    assign par = ^sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            par_q    <= 1'b0;
            vld_pipe <= '0;
        end else begin
            sync1    <= sw;
            sync2    <= sync1;
            par_q    <= par;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
    end

    // par_q only matches the filled synchroniser from the third edge on,
    // so hold events off until then.
    assign evt = vld_pipe[2] & (par ^ par_q);

endmodule

// File: rtl/lamp_timer_ctrl.sv
// Timed lamp controller: switch events light the lamp for ON_CYC cycles,
// followed by an optional blinking warning phase before switch-off.
module lamp_timer_ctrl
    import lamp_timer_pkg::*;
#(
    parameter int N_SW       = 3,
    parameter int CNT_W      = 16,
    parameter int ON_CYC     = 300,
    parameter int WARN_CYC   = 50,
    parameter int BLINK_HALF = 5,
    parameter int MODE       = MODE_TOGGLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw,
    input  logic             force_on,
    output logic             lamp,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] remain
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] WARN_LOAD = CNT_W'(WARN_CYC - 1);
    localparam logic [BW-1:0]    BLK_LAST  = BW'(BLINK_HALF - 1);

    if (ON_CYC < 1 || longint'(ON_CYC) >= (longint'(1) << CNT_W)) begin : g_bad_on
        $error("lamp_timer_ctrl: ON_CYC out of range");
    end
    if (WARN_CYC < 0 || longint'(WARN_CYC) >= (longint'(1) << CNT_W)) begin : g_bad_warn
        $error("lamp_timer_ctrl: WARN_CYC out of range");
    end

    logic             evt;
    lamp_state_t      st_q, st_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             ph_q, ph_d;
    logic             lamp_q, lamp_d;

    sw_event_sync #(.N_SW(N_SW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .evt   (evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_OFF;
            rem_q  <= '0;
            bcnt_q <= '0;
            ph_q   <= 1'b0;
            lamp_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            rem_q  <= rem_d;
            bcnt_q <= bcnt_d;
            ph_q   <= ph_d;
            lamp_q <= lamp_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        rem_d  = rem_q;
        bcnt_d = '0;
        ph_d   = 1'b0;
        // force_on reloads every cycle, so release restarts the full on-time
        if (force_on) begin
            st_d  = ST_ON;
            rem_d = ON_LOAD;
        end else begin
            case (st_q)
                ST_OFF: begin
                    if (evt) begin
                        st_d  = ST_ON;
                        rem_d = ON_LOAD;
                    end
                end
                ST_ON: begin
                    if (evt) begin
                        if (MODE == MODE_RETRIG) begin
                            rem_d = ON_LOAD;
                        end else begin
                            st_d  = ST_OFF;
                            rem_d = '0;
                        end
                    end else if (rem_q == '0) begin
                        if (WARN_CYC > 0) begin
                            st_d  = ST_WARN;
                            rem_d = WARN_LOAD;
                        end else begin
                            st_d  = ST_OFF;
                        end
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
                ST_WARN: begin
                    if (evt) begin
                        st_d  = ST_ON;
                        rem_d = ON_LOAD;
                    end else if (rem_q == '0) begin
                        st_d  = ST_OFF;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
                default: begin
                    st_d  = ST_OFF;
                    rem_d = '0;
                end
            endcase
        end
        // Blink phase restarts dark on every WARN entry.
        if (st_d == ST_WARN && st_q == ST_WARN) begin
            if (bcnt_q == BLK_LAST) begin
                bcnt_d = '0;
                ph_d   = ~ph_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
                ph_d   = ph_q;
            end
        end
        lamp_d = (st_d == ST_ON) || (st_d == ST_WARN && ph_d);
    end

    assign lamp   = lamp_q;
    assign state  = st_q;
    assign remain = rem_q;

endmodule

// File: tb/tb_lamp_timer_ctrl.sv
// Directed bench for lamp_timer_ctrl: a per-cycle vector table on a
// retrigger-mode instance plus short sequences on toggle and no-warn instances.
module tb_lamp_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  sw1, sw0, sww;
    logic        f1, f0, fw;
    logic        lamp1, lamp0, lampw;
    logic [1:0]  st1, st0, stw;
    logic [15:0] rem1, rem0, remw;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] sw;
        logic       frc;
        logic       lp;
        logic [1:0] st;
        int         rem;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    lamp_timer_ctrl #(.N_SW(3), .CNT_W(16), .ON_CYC(10), .WARN_CYC(4),
                      .BLINK_HALF(1), .MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .sw(sw1), .force_on(f1),
        .lamp(lamp1), .state(st1), .remain(rem1));

    lamp_timer_ctrl #(.N_SW(3), .CNT_W(16), .ON_CYC(10), .WARN_CYC(4),
                      .BLINK_HALF(1), .MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .sw(sw0), .force_on(f0),
        .lamp(lamp0), .state(st0), .remain(rem0));

    lamp_timer_ctrl #(.N_SW(3), .CNT_W(16), .ON_CYC(10), .WARN_CYC(0),
                      .BLINK_HALF(1), .MODE(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .sw(sww), .force_on(fw),
        .lamp(lampw), .state(stw), .remain(remw));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input logic lp, input logic [1:0] st,
                        input logic [15:0] rem, input int elp, input int est, input int erem);
        chk({nm, ".lamp"},   32'(lp),  elp);
        chk({nm, ".state"},  32'(st),  est);
        chk({nm, ".remain"}, 32'(rem), erem);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [2:0] s, input logic f, input logic lp,
                       input logic [1:0] st, input int rem);
        vec_t v;
        v.sw = s; v.frc = f; v.lp = lp; v.st = st; v.rem = rem;
        tbl.push_back(v);
    endtask

    task automatic on_run(input logic [2:0] s, input int hi, input int lo);
        for (int r = hi; r >= lo; r--) add(s, 1'b0, 1'b1, 2'd1, r);
    endtask

    task automatic warn_run(input logic [2:0] s);
        add(s, 1'b0, 1'b0, 2'd2, 3);
        add(s, 1'b0, 1'b1, 2'd2, 2);
        add(s, 1'b0, 1'b0, 2'd2, 1);
        add(s, 1'b0, 1'b1, 2'd2, 0);
    endtask

    initial begin
        sw1 = 3'b101; sw0 = 3'b000; sww = 3'b000;
        f1 = 1'b0; f0 = 1'b0; fw = 1'b0;

        // single flip: 2 edges of sync latency, 10 ON, 4 WARN blinking, OFF
        add(3'b100, 0, 0, 0, 0); add(3'b100, 0, 0, 0, 0);
        on_run(3'b100, 9, 0); warn_run(3'b100); add(3'b100, 0, 0, 0, 0);
        // retrigger 5 cycles after lighting: 15 lit + 4 warn
        add(3'b110, 0, 0, 0, 0); add(3'b110, 0, 0, 0, 0);
        on_run(3'b110, 9, 7); on_run(3'b010, 6, 5); on_run(3'b010, 9, 0);
        warn_run(3'b010); add(3'b010, 0, 0, 0, 0);
        // event during WARN, then event landing on remain=0 in ON
        add(3'b011, 0, 0, 0, 0); add(3'b011, 0, 0, 0, 0);
        on_run(3'b011, 9, 0);
        add(3'b001, 0, 0, 2, 3); add(3'b001, 0, 1, 2, 2);
        on_run(3'b001, 9, 2); on_run(3'b000, 1, 0); on_run(3'b000, 9, 0);
        warn_run(3'b000); add(3'b000, 0, 0, 0, 0);
        // force_on for 20 cycles with flips, then full timing from release
        for (int r = 0; r < 20; r++)
            add((r < 3) ? 3'b000 : (r < 8) ? 3'b100 : (r < 13) ? 3'b110 : 3'b111,
                1'b1, 1'b1, 2'd1, 9);
        on_run(3'b111, 8, 0); warn_run(3'b111); add(3'b111, 0, 0, 0, 0);

        // reset with switches held high: no spurious event
        repeat (2) tick;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk3($sformatf("rst_m1_c%0d", i), lamp1, st1, rem1, 0, 0, 0);
        end
        chk3("rst_m0", lamp0, st0, rem0, 0, 0, 0);

        foreach (tbl[i]) begin
            sw1 = tbl[i].sw;
            f1  = tbl[i].frc;
            tick;
            chk3($sformatf("vec%0d", i), lamp1, st1, rem1,
                 int'(tbl[i].lp), int'(tbl[i].st), tbl[i].rem);
        end

        // toggle mode: second flip switches off 3 edges later
        sw0 = 3'b010; tick; tick; tick;
        chk3("m0_on", lamp0, st0, rem0, 1, 1, 9);
        tick; tick;
        sw0 = 3'b110; tick;
        chk3("m0_hold", lamp0, st0, rem0, 1, 1, 6);
        tick;
        chk3("m0_still", lamp0, st0, rem0, 1, 1, 5);
        tick;
        chk3("m0_off", lamp0, st0, rem0, 0, 0, 0);
        // 1-cycle pulse lights the lamp for exactly one cycle
        sw0 = 3'b111; tick;
        sw0 = 3'b110; tick;
        tick;
        chk3("pulse_on", lamp0, st0, rem0, 1, 1, 9);
        tick;
        chk3("pulse_off", lamp0, st0, rem0, 0, 0, 0);

        // no warning phase: ON straight to OFF
        sww = 3'b001; tick; tick; tick;
        chk3("w0_on", lampw, stw, remw, 1, 1, 9);
        repeat (9) tick;
        chk3("w0_last", lampw, stw, remw, 1, 1, 0);
        tick;
        chk3("w0_off", lampw, stw, remw, 0, 0, 0);

        // asynchronous reset mid-ON
        sw1 = 3'b011; tick; tick; tick;
        chk3("pre_rst", lamp1, st1, rem1, 1, 1, 9);
        #2 rst_n = 1'b0;
        #1 chk3("async_rst", lamp1, st1, rem1, 0, 0, 0);
        tick;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
